// File: rtl/tty_write_arbiter.sv
// tty_write_arbiter: three source FIFOs drained round-robin into the VGA text-memory write port
module tty_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       cpu_write,
  input  logic [7:0] cpu_wdata,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  input  logic       cpu_read,
  input  logic       vm_ready,
  output logic       vm_write,
  output logic [7:0] vm_data,
  output logic [1:0] vm_src,
  output logic [7:0] key_data,
  output logic       key_pending,
  output logic [2:0] ovf,
  input  logic       ovf_clr
);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] MSB = {1'b1, {AW{1'b0}}};
  logic [7:0] r_mem [3][DEPTH];
  logic [AW:0] r_wp [3];
  logic [AW:0] r_rp [3];
  logic [7:0] w_din [3];
  logic [2:0] w_stb, w_empty, w_full, w_push, w_drop, w_pop;
  logic [1:0] r_last, w_c0, w_c1, w_c2, w_gnt;
  logic w_any, w_load;
  logic r_vm_write;
  logic [7:0] r_vm_data, r_key_data;
  logic [1:0] r_vm_src;
  logic r_key_pending;
  logic [2:0] r_ovf;

  function automatic logic [1:0] nxt(input logic [1:0] s);
    return s == 2'd2 ? 2'd0 : s + 2'd1;
  endfunction

  assign w_stb  = {kbd_valid, uart_valid, cpu_write};
  assign w_din[0] = cpu_wdata;
  assign w_din[1] = uart_data;
  assign w_din[2] = kbd_data;

  // Per-FIFO status; a full FIFO still accepts a push when it is popped at the same edge.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_empty[i] = r_wp[i] == r_rp[i];
      w_full[i]  = (r_wp[i] ^ r_rp[i]) == MSB;
      w_push[i]  = w_stb[i] && (!w_full[i] || w_pop[i]);
      w_drop[i]  = w_stb[i] && !w_push[i];
    end
  end

  // Round-robin search starting after the last granted source.
  always_comb begin
    w_c0  = nxt(r_last);
    w_c1  = nxt(w_c0);
    w_c2  = nxt(w_c1);
    w_gnt = !w_empty[w_c0] ? w_c0 : !w_empty[w_c1] ? w_c1 : w_c2;
  end

  assign w_any  = ~&w_empty;
  assign w_load = !r_vm_write || vm_ready;
  assign w_pop  = (w_load && w_any) ? (3'b001 << w_gnt) : 3'b000;

  // FIFO storage and pointers.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wp[i][AW-1:0]] <= w_din[i];
          r_wp[i] <= r_wp[i] + ONE;
        end
        if (w_pop[i]) r_rp[i] <= r_rp[i] + ONE;
      end
    end
  end

  // Output holding slot: reload whenever empty or being consumed.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_vm_write <= 1'b0;
      r_vm_data  <= 8'h00;
      r_vm_src   <= 2'd0;
      r_last     <= 2'd2;
    end else if (w_load) begin
      r_vm_write <= w_any;
      if (w_any) begin
        r_vm_data <= r_mem[w_gnt][r_rp[w_gnt][AW-1:0]];
        r_vm_src  <= w_gnt;
        r_last    <= w_gnt;
      end
    end
  end

  // Keyboard readback latch; a new key beats a simultaneous read.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_key_data    <= 8'h00;
      r_key_pending <= 1'b0;
    end else if (kbd_valid) begin
      r_key_data    <= kbd_data;
      r_key_pending <= 1'b1;
    end else if (cpu_read) begin
      r_key_pending <= 1'b0;
    end
  end

  // Sticky overflow flags; a new drop beats a simultaneous clear.
  always_ff @(posedge clk_50mhz) begin
    if (rst) r_ovf <= 3'b000;
    else r_ovf <= (ovf_clr ? 3'b000 : r_ovf) | w_drop;
  end

  assign vm_write    = r_vm_write;
  assign vm_data     = r_vm_data;
  assign vm_src      = r_vm_src;
  assign key_data    = r_key_data;
  assign key_pending = r_key_pending;
  assign ovf         = r_ovf;
endmodule
